// File: rtl/gol_pkg.sv
// gol_pkg: shared grid geometry, grid type, controller state encoding and helpers
package gol_pkg;
   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int GEN_W = 16;
   localparam int PERIOD_W = 26;
   localparam int SETTLE_CYC = 2;
   typedef logic [ROWS-1:0][COLS-1:0] grid_t;
   typedef enum logic [1:0] {S_EDIT = 2'd0, S_SETTLE = 2'd1, S_RUN = 2'd2} ctrl_state_e;
   function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
      return (&v) ? v : v + GEN_W'(1);
   endfunction
endpackage

// File: rtl/gol_generation_ctrl_if.sv
// gol_generation_ctrl_if: control inputs, update-stage grid and status outputs of the generation controller
interface gol_generation_ctrl_if #(parameter int PERIOD_W = gol_pkg::PERIOD_W);
   import gol_pkg::*;
   logic run;
   logic step;
   logic clear;
   logic edit_toggle;
   logic [3:0] cursor_row;
   logic [3:0] cursor_col;
   logic [PERIOD_W-1:0] period;
   grid_t grid_next;
   grid_t grid;
   logic [GEN_W-1:0] gen_count;
   logic [1:0] state_o;
   logic stable;
   logic extinct;
   modport master (
      output run, step, clear, edit_toggle, cursor_row, cursor_col, period, grid_next,
      input grid, gen_count, state_o, stable, extinct
   );
   modport slave (
      input run, step, clear, edit_toggle, cursor_row, cursor_col, period, grid_next,
      output grid, gen_count, state_o, stable, extinct
   );
endinterface

// File: rtl/gol_tick_timer.sv
// gol_tick_timer: run-mode generation tick counter with hold, clear and terminal count
module gol_tick_timer #(
   parameter int W = 26
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   input  logic [W-1:0] period,
   output logic tc
);
   logic [W-1:0] tick;
   logic [W-1:0] term;
   // >= rather than == so a period shrunk below the current count fires at once
   assign term = (period == '0) ? '0 : period - W'(1);
   assign tc = tick >= term;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) tick <= '0;
      else if (clr) tick <= '0;
      else if (en) tick <= tick + W'(1);
endmodule

// File: rtl/gol_generation_ctrl.sv
// gol_generation_ctrl: owns the live Game-of-Life grid, commits the update stage's
// next generation on step or periodically in run mode, and handles cell editing
module gol_generation_ctrl
   import gol_pkg::*;
#(
   parameter int ROWS = gol_pkg::ROWS,
   parameter int COLS = gol_pkg::COLS,
   parameter int PERIOD_W = gol_pkg::PERIOD_W,
   parameter int SETTLE_CYC = gol_pkg::SETTLE_CYC
) (
   input logic clk,
   input logic reset_n,
   gol_generation_ctrl_if.slave bus
);
   localparam int SW = $clog2(SETTLE_CYC + 2);
   ctrl_state_e state, state_d;
   logic [SW-1:0] settle_cnt, settle_d;
   logic step_pending, pending_d;
   grid_t grid, grid_d, cell_mask;
   logic [GEN_W-1:0] gen_count, gen_d;
   logic tc, step_in, clear_in, toggle_in, edit_wr, commit_step, commit_run, commit;
   always_comb begin
      step_in = bus.step && !bus.run;
      clear_in = bus.clear && !bus.run;
      toggle_in = bus.edit_toggle && !bus.run &&
                  (int'(bus.cursor_row) < ROWS) && (int'(bus.cursor_col) < COLS);
      edit_wr = clear_in || toggle_in;
      // an edit in the same cycle wins; the step waits for the grid to settle again
      commit_step = (state == S_EDIT) && !edit_wr && (step_pending || step_in);
      commit_run = (state == S_RUN) && bus.run && tc;
      commit = commit_step || commit_run;
      cell_mask = '0;
      cell_mask[bus.cursor_row][bus.cursor_col] = 1'b1;
      grid_d = clear_in ? '0 : toggle_in ? (grid ^ cell_mask) : commit ? bus.grid_next : grid;
      gen_d = clear_in ? '0 : commit ? sat_inc(gen_count) : gen_count;
      pending_d = commit_step ? 1'b0 : step_in ? 1'b1 : clear_in ? 1'b0 : step_pending;
      state_d = state;
      settle_d = settle_cnt;
      if (edit_wr || commit) begin
         state_d = S_SETTLE;
         settle_d = SW'(SETTLE_CYC);
      end else if (state == S_SETTLE) begin
         settle_d = (settle_cnt == '0) ? '0 : settle_cnt - SW'(1);
         state_d = (settle_cnt > SW'(1)) ? S_SETTLE : bus.run ? S_RUN : S_EDIT;
      end else if (state == S_EDIT) begin
         state_d = bus.run ? S_RUN : S_EDIT;
      end else begin
         state_d = bus.run ? S_RUN : S_EDIT;
      end
   end
   // the tick keeps counting through settle so the interval is max(period, settle+1)
   gol_tick_timer #(.W(PERIOD_W)) u_timer (
      .clk(clk),
      .reset_n(reset_n),
      .en(bus.run),
      .clr(!bus.run || state == S_EDIT || commit_run),
      .period(bus.period),
      .tc(tc)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= S_SETTLE;
         settle_cnt <= SW'(SETTLE_CYC);
         step_pending <= 1'b0;
         grid <= '0;
         gen_count <= '0;
      end else begin
         state <= state_d;
         settle_cnt <= settle_d;
         step_pending <= pending_d;
         grid <= grid_d;
         gen_count <= gen_d;
      end
   assign bus.grid = grid;
   assign bus.gen_count = gen_count;
   assign bus.state_o = state;
   assign bus.stable = (state != S_SETTLE) && (bus.grid_next == grid);
   assign bus.extinct = (grid == '0);
endmodule

// File: tb/tb_gol_generation_ctrl.sv
// tb_gol_generation_ctrl: table-driven check of editing, stepping, run timing and
// async reset, with grid_next supplied by a registered Game-of-Life model
module tb_gol_generation_ctrl;
   import gol_pkg::*;
   localparam int E = 0, S = 1, R = 2;
   localparam int Z = 0, H = 1, V = 2, VC = 3, BL = 4, HC = 5, X = 7;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   gol_generation_ctrl_if bus ();
   gol_generation_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   function automatic grid_t life(input grid_t g);
      grid_t nx;
      nx = '0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            int n;
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 && c + dc >= 0 && c + dc < 16)
                     n += int'(g[r+dr][c+dc]);
            nx[r][c] = (n == 3) || (g[r][c] && n == 2);
         end
      return nx;
   endfunction
   always @(posedge clk) bus.grid_next <= life(bus.grid);
   int n_run = 0;
   int n_fail = 0;
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   typedef struct {
      logic run, step, clear, tog;
      logic [3:0] r, c;
      logic [25:0] period;
      int st, gen, g, stb;
   } vec_t;
   function automatic vec_t v(input int ru, sp, cl, tg, r, c, p, st, gen, g, stb);
      vec_t x;
      x.run = 1'(ru); x.step = 1'(sp); x.clear = 1'(cl); x.tog = 1'(tg);
      x.r = 4'(r); x.c = 4'(c); x.period = 26'(p);
      x.st = st; x.gen = gen; x.g = g; x.stb = stb;
      return x;
   endfunction
   vec_t vecs[$];
   grid_t refg[6];
   initial begin
      refg[Z] = '0;
      refg[H] = '0; refg[H][8][7] = 1; refg[H][8][8] = 1; refg[H][8][9] = 1;
      refg[V] = '0; refg[V][7][8] = 1; refg[V][8][8] = 1; refg[V][9][8] = 1;
      refg[VC] = refg[V]; refg[VC][0][0] = 1;
      refg[HC] = refg[H]; refg[HC][0][0] = 1;
      refg[BL] = '0; refg[BL][3][3] = 1; refg[BL][3][4] = 1; refg[BL][4][3] = 1; refg[BL][4][4] = 1;
      // run step clr tog row col period | state gen grid stable(2=skip)
      vecs.push_back(v(0,0,0,1, 8,7,4, S,0,X,0));
      vecs.push_back(v(0,0,0,1, 8,8,4, S,0,X,0));
      vecs.push_back(v(0,0,0,1, 8,9,4, S,0,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,0,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,0,H,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, S,1,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,1,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,1,V,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, S,2,H,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, S,2,H,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, E,2,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,3,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,3,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,3,V,0));
      vecs.push_back(v(0,0,0,1, 0,0,4, S,3,VC,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, S,3,VC,0));
      vecs.push_back(v(0,1,0,0, 0,0,4, E,3,VC,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,4,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,4,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,4,H,0));
      vecs.push_back(v(0,1,0,1, 0,0,4, S,4,HC,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,4,HC,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,4,HC,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,5,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,5,V,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,5,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,5,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,5,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,5,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,5,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, S,6,H,0));
      vecs.push_back(v(1,0,1,0, 0,0,4, S,6,H,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,6,H,0));
      vecs.push_back(v(1,0,0,1, 0,0,4, R,6,H,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, S,7,V,0));
      vecs.push_back(v(1,1,0,0, 0,0,4, S,7,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,7,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, R,7,V,0));
      vecs.push_back(v(1,0,0,0, 0,0,4, S,8,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,8,H,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,8,H,0));
      vecs.push_back(v(0,0,1,0, 0,0,4, S,0,Z,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, S,0,Z,0));
      vecs.push_back(v(0,0,0,0, 0,0,4, E,0,Z,1));
      vecs.push_back(v(0,0,0,1, 3,3,4, S,0,X,0));
      vecs.push_back(v(0,0,0,1, 3,4,4, S,0,X,0));
      vecs.push_back(v(0,0,0,1, 4,3,4, S,0,X,0));
      vecs.push_back(v(0,0,0,1, 4,4,4, S,0,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,0, S,0,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,0, R,0,BL,1));
      vecs.push_back(v(1,0,0,0, 0,0,0, S,1,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,0, S,1,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,0, R,1,BL,1));
      vecs.push_back(v(1,0,0,0, 0,0,0, S,2,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,1, S,2,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,1, R,2,BL,1));
      vecs.push_back(v(1,0,0,0, 0,0,1, S,3,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,1, S,3,BL,0));
      vecs.push_back(v(1,0,0,0, 0,0,1, R,3,BL,1));
      bus.run = 0; bus.step = 0; bus.clear = 0; bus.edit_toggle = 0;
      bus.cursor_row = 0; bus.cursor_col = 0; bus.period = 26'd4;
      repeat (3) @(negedge clk);
      chk("reset state", bus.state_o, S);
      chk("reset gen", bus.gen_count, 0);
      chk("reset grid", bus.grid, '0);
      chk("reset extinct", bus.extinct, 1);
      chk("reset stable", bus.stable, 0);
      reset_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.run = vecs[i].run; bus.step = vecs[i].step; bus.clear = vecs[i].clear;
         bus.edit_toggle = vecs[i].tog; bus.cursor_row = vecs[i].r; bus.cursor_col = vecs[i].c;
         bus.period = vecs[i].period;
         @(negedge clk);
         chk($sformatf("row%0d state", i), bus.state_o, vecs[i].st);
         chk($sformatf("row%0d gen", i), bus.gen_count, vecs[i].gen);
         if (vecs[i].g != X) begin
            chk($sformatf("row%0d grid", i), bus.grid, refg[vecs[i].g]);
            chk($sformatf("row%0d extinct", i), bus.extinct, vecs[i].g == Z);
         end
         if (vecs[i].stb != 2) chk($sformatf("row%0d stable", i), bus.stable, vecs[i].stb);
      end
      bus.step = 0; bus.clear = 0; bus.edit_toggle = 0;
      #2 reset_n = 1'b0;
      #1;
      chk("async rst state", bus.state_o, S);
      chk("async rst gen", bus.gen_count, 0);
      chk("async rst grid", bus.grid, '0);
      chk("async rst extinct", bus.extinct, 1);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post rst settle1", bus.state_o, S);
      @(negedge clk);
      chk("post rst run", bus.state_o, R);
      chk("post rst gen", bus.gen_count, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
